// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid register. The skid entry lets in_ready come
// straight from registered occupancy, so no combinational path runs from out_ready.
module pipe_stage_skid #(
  parameter int DATA_W = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers are reset as well because they are visible on out_data.
    if (!reset_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q <= in_data;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            skid_q <= in_data;
            state  <= ST_FULL;
          end else if (out_xfer) begin
            state  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Upstream is stalled here, so only the drain of main matters.
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Backpressure counter: saturates, and survives flush so stall statistics are not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
